// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction fetch request controller: issues word-aligned bus fetches, tracks
// outstanding transactions and forwards responses into the fetch FIFO, dropping stale ones after a branch.
module ibex_fetch_req_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        fifo_ready_i,
  output logic        fifo_clear_o,
  output logic        fifo_valid_o,
  output logic [31:0] fifo_addr_o,
  output logic [31:0] fifo_rdata_o,
  output logic        fifo_err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(NUM_REQS + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(NUM_REQS);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_GNT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [29:0]         fetch_addr_q, fetch_addr_d;
  logic [29:0]         pend_addr_q, pend_addr_d;
  logic                pend_disc_q, pend_disc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_REQS-1:0] disc_q, disc_d;

  logic [29:0]         branch_word;
  logic [29:0]         issue_word;
  logic                issue_ok;
  logic                granted;
  logic                append_disc;
  logic [CW-1:0]       append_idx;

  assign branch_word = branch_addr_i[31:2];
  // Counting against cnt_q (not cnt_d) keeps a retiring slot occupied until next cycle.
  assign issue_ok    = req_i & fifo_ready_i & (cnt_q < MaxCnt);
  assign granted     = instr_req_o & instr_gnt_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      pend_addr_q  <= '0;
      pend_disc_q  <= 1'b0;
      cnt_q        <= '0;
      disc_q       <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pend_addr_q  <= pend_addr_d;
      pend_disc_q  <= pend_disc_d;
      cnt_q        <= cnt_d;
      disc_q       <= disc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pend_addr_d  = pend_addr_q;
    pend_disc_d  = pend_disc_q;
    instr_req_o  = 1'b0;
    issue_word   = fetch_addr_q;
    append_disc  = 1'b0;
    case (state_q)
      IDLE: begin
        issue_word  = branch_i ? branch_word : fetch_addr_q;
        instr_req_o = issue_ok;
        if (branch_i) fetch_addr_d = branch_word;
        if (issue_ok) begin
          if (instr_gnt_i) begin
            fetch_addr_d = issue_word + 30'd1;
          end else begin
            state_d     = WAIT_GNT;
            pend_addr_d = issue_word;
            pend_disc_d = 1'b0;
          end
        end
      end
      WAIT_GNT: begin
        // The bus request is never retracted; a branch only marks it stale.
        issue_word  = pend_addr_q;
        instr_req_o = 1'b1;
        append_disc = pend_disc_q | branch_i;
        if (branch_i) fetch_addr_d = branch_word;
        if (instr_gnt_i) begin
          state_d     = IDLE;
          pend_disc_d = 1'b0;
          if (!append_disc) fetch_addr_d = pend_addr_q + 30'd1;
        end else if (branch_i) begin
          pend_disc_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Discard queue: slot 0 is the oldest outstanding transaction.
  always_comb begin
    disc_d     = disc_q;
    append_idx = cnt_q - CW'(instr_rvalid_i);
    if (branch_i) disc_d = '1;
    if (instr_rvalid_i) disc_d = disc_d >> 1;
    if (granted) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (CW'(i) == append_idx) disc_d[i] = append_disc;
      end
    end
    cnt_d = cnt_q + CW'(granted) - CW'(instr_rvalid_i);
  end

  assign instr_addr_o = {issue_word, 2'b00};
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = branch_i ? branch_addr_i : {fetch_addr_q, 2'b00};
  assign fifo_valid_o = instr_rvalid_i & ~disc_q[0] & ~branch_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign busy_o       = instr_req_o | (cnt_q != '0);

`ifndef SYNTHESIS
  rvalid_needs_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> (cnt_q != '0));

  no_double_branch_in_wait: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (branch_i && state_q == WAIT_GNT) |=> !(branch_i && state_q == WAIT_GNT));
`endif

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Bench for ibex_fetch_req_ctrl: directed scenarios then random traffic, all
// checked against a queue-based model of outstanding fetches.
module tb_ibex_fetch_req_ctrl;

  localparam int N = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0, branch_i = 1'b0, fifo_ready_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        fifo_clear_o, fifo_valid_o, fifo_err_o, busy_o;
  logic [31:0] fifo_addr_o, fifo_rdata_o, instr_addr_o;
  logic        instr_req_o;
  logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;

  ibex_fetch_req_ctrl #(.NUM_REQS(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .fifo_ready_i(fifo_ready_i),
    .fifo_clear_o(fifo_clear_o), .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o),
    .fifo_rdata_o(fifo_rdata_o), .fifo_err_o(fifo_err_o), .instr_req_o(instr_req_o),
    .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: addresses and discard marks of outstanding fetches, oldest first.
  logic [31:0] exp_q[$];
  bit          dsc_q[$];
  logic [29:0] m_next = '0;
  logic [29:0] m_pend_addr = '0;
  bit          m_pend = 1'b0, m_pend_disc = 1'b0, m_prev_bw = 1'b0;
  bit          e_req;
  logic [29:0] e_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic eval(input bit req, input bit br, input logic [31:0] ba, input bit fr,
                      input bit gnt, input bit rv, input bit err);
    bit e_valid;
    req_i          = req;
    branch_i       = br;
    branch_addr_i  = ba;
    fifo_ready_i   = fr;
    instr_gnt_i    = gnt;
    instr_rvalid_i = rv && (exp_q.size() > 0);
    instr_err_i    = err;
    instr_rdata_i  = $urandom;
    e_req   = m_pend || (req && fr && (exp_q.size() < N));
    e_word  = m_pend ? m_pend_addr : (br ? ba[31:2] : m_next);
    e_valid = instr_rvalid_i && !dsc_q[0] && !br;
    @(negedge clk_i);
    chk("instr_req", 32'(instr_req_o), 32'(e_req));
    if (e_req) chk("instr_addr", instr_addr_o, {e_word, 2'b00});
    chk("fifo_valid", 32'(fifo_valid_o), 32'(e_valid));
    if (instr_rvalid_i) begin
      chk("fifo_rdata", fifo_rdata_o, instr_rdata_i);
      chk("fifo_err", 32'(fifo_err_o), 32'(err));
    end
    chk("fifo_clear", 32'(fifo_clear_o), 32'(br));
    chk("fifo_addr", fifo_addr_o, br ? ba : {m_next, 2'b00});
    chk("busy", 32'(busy_o), 32'(e_req || (exp_q.size() != 0)));
  endtask

  task automatic tick();
    bit          g;
    logic [29:0] bw;
    logic [29:0] a;
    @(posedge clk_i);
    g  = e_req && instr_gnt_i;
    bw = branch_addr_i[31:2];
    m_prev_bw = branch_i && m_pend;
    if (instr_rvalid_i) begin
      void'(exp_q.pop_front());
      void'(dsc_q.pop_front());
    end
    if (branch_i) foreach (dsc_q[i]) dsc_q[i] = 1'b1;
    if (m_pend) begin
      if (g) begin
        exp_q.push_back({m_pend_addr, 2'b00});
        dsc_q.push_back(m_pend_disc || branch_i);
        if (branch_i) m_next = bw;
        else if (!m_pend_disc) m_next = m_pend_addr + 30'd1;
        m_pend = 1'b0;
      end else if (branch_i) begin
        m_pend_disc = 1'b1;
        m_next = bw;
      end
    end else begin
      a = branch_i ? bw : m_next;
      if (g) begin
        exp_q.push_back({a, 2'b00});
        dsc_q.push_back(1'b0);
        m_next = a + 30'd1;
      end else if (e_req) begin
        m_pend = 1'b1;
        m_pend_addr = a;
        m_pend_disc = 1'b0;
        m_next = a;
      end else if (branch_i) begin
        m_next = bw;
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (exp_q.size() != 0 || m_pend); k++) begin
      eval(0, 0, 32'h0, 1, 1, 1, 0);
      tick();
    end
    eval(0, 0, 32'h0, 1, 0, 0, 0);
    chk("drained_busy", 32'(busy_o), 32'h0);
    tick();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_req", 32'(instr_req_o), 32'h0);
    chk("rst_valid", 32'(fifo_valid_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_fifo_addr", fifo_addr_o, 32'h0);
    branch_i = 1'b1;
    branch_addr_i = 32'h1234;
    #1;
    chk("rst_clear", 32'(fifo_clear_o), 32'h1);
    chk("rst_clear_addr", fifo_addr_o, 32'h1234);
    branch_i = 1'b0;
    branch_addr_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Streaming with gnt always high and one-cycle response latency
    for (int i = 0; i < 6; i++) begin
      eval(1, 0, 32'h0, 1, 1, 1, 0);
      chk("seq_addr", instr_addr_o, 32'(i * 4));
      chk("seq_push", 32'(fifo_valid_o), 32'(i > 0));
      tick();
    end
    drain();

    // Grant withheld at 0x100 while req_i drops
    eval(1, 1, 32'h100, 1, 0, 0, 0);
    tick();
    repeat (3) begin
      eval(0, 0, 32'h0, 1, 0, 0, 0);
      chk("hold_req", 32'(instr_req_o), 32'h1);
      chk("hold_addr", instr_addr_o, 32'h100);
      tick();
    end
    eval(0, 0, 32'h0, 1, 1, 0, 0);
    chk("hold_gnt_addr", instr_addr_o, 32'h100);
    tick();
    drain();

    // Branch to 0x1002 with 0x20 and 0x24 outstanding
    eval(1, 1, 32'h20, 1, 1, 0, 0);
    tick();
    eval(1, 0, 32'h0, 1, 1, 0, 0);
    chk("br_second_addr", instr_addr_o, 32'h24);
    tick();
    eval(1, 1, 32'h1002, 1, 1, 0, 0);
    chk("br_clear", 32'(fifo_clear_o), 32'h1);
    chk("br_full_noreq", 32'(instr_req_o), 32'h0);
    tick();
    eval(1, 0, 32'h0, 1, 1, 1, 0);
    chk("br_old0_drop", 32'(fifo_valid_o), 32'h0);
    tick();
    eval(1, 0, 32'h0, 1, 1, 1, 0);
    chk("br_old1_drop", 32'(fifo_valid_o), 32'h0);
    chk("br_target_req", instr_addr_o, 32'h1000);
    tick();
    eval(0, 0, 32'h0, 1, 0, 1, 0);
    chk("br_target_push", 32'(fifo_valid_o), 32'h1);
    tick();
    drain();

    // Branch to 0x2000 while waiting for grant at 0x40
    eval(1, 1, 32'h40, 1, 0, 0, 0);
    tick();
    eval(1, 1, 32'h2000, 1, 0, 0, 0);
    chk("wbr_hold_addr", instr_addr_o, 32'h40);
    tick();
    eval(1, 0, 32'h0, 1, 1, 0, 0);
    chk("wbr_gnt_addr", instr_addr_o, 32'h40);
    tick();
    eval(1, 0, 32'h0, 1, 1, 1, 0);
    chk("wbr_stale_drop", 32'(fifo_valid_o), 32'h0);
    chk("wbr_target_addr", instr_addr_o, 32'h2000);
    tick();
    eval(0, 0, 32'h0, 1, 0, 1, 0);
    chk("wbr_target_push", 32'(fifo_valid_o), 32'h1);
    tick();
    drain();

    // Full outstanding count with FIFO back-pressure
    eval(1, 0, 32'h0, 1, 1, 0, 0);
    tick();
    eval(1, 0, 32'h0, 1, 1, 0, 0);
    tick();
    eval(1, 0, 32'h0, 0, 1, 0, 0);
    chk("full_noreq", 32'(instr_req_o), 32'h0);
    tick();
    eval(1, 0, 32'h0, 1, 1, 1, 0);
    chk("full_retire_noreq", 32'(instr_req_o), 32'h0);
    tick();
    eval(1, 0, 32'h0, 1, 1, 0, 0);
    chk("full_resume", 32'(instr_req_o), 32'h1);
    tick();
    drain();

    // Address wrap and bus error passthrough
    eval(1, 1, 32'hFFFF_FFFC, 1, 1, 0, 0);
    chk("wrap_top", instr_addr_o, 32'hFFFF_FFFC);
    tick();
    eval(1, 0, 32'h0, 1, 1, 0, 0);
    chk("wrap_zero", instr_addr_o, 32'h0);
    tick();
    eval(0, 0, 32'h0, 1, 0, 1, 1);
    chk("wrap_err", 32'(fifo_err_o), 32'h1);
    tick();
    drain();

    // Random traffic
    repeat (600) begin
      bit br;
      br = ($urandom_range(0, 7) == 0) && !(m_prev_bw && m_pend);
      eval($urandom_range(0, 3) != 0, br, $urandom, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
